fpu_misc_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational sign-injection FPU. It executes the RISC-V "misc" single-cycle float ops (sign injection, min/max, compare) on a configurable IEEE-style format. Results pass through a STAGES-deep register pipeline with valid/ready handshakes on both sides and a pass-through tag. It sits between issue and writeback in the core's FP path.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_misc_core.sv | 94 +++++++++
 rtl/fpu_misc_pipe.sv | 99 +++++++++
 tb/tb_fpu_misc_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared opcode constants and payload pieces for the FP misc pipeline.
package fpu_pkg;

    localparam logic [6:0] FUNCT7_SGNJ   = 7'h10;
    localparam logic [6:0] FUNCT7_MINMAX = 7'h14;
    localparam logic [6:0] FUNCT7_CMP    = 7'h50;

    localparam logic [2:0] F3_SGNJ  = 3'd0;
    localparam logic [2:0] F3_SGNJN = 3'd1;
    localparam logic [2:0] F3_SGNJX = 3'd2;
    localparam logic [2:0] F3_MIN   = 3'd0;
    localparam logic [2:0] F3_MAX   = 3'd1;
    localparam logic [2:0] F3_FLE   = 3'd0;
    localparam logic [2:0] F3_FLT   = 3'd1;
    localparam logic [2:0] F3_FEQ   = 3'd2;

    // Flag half of the stage payload; y and tag widths are set per instance.
    typedef struct packed {
        logic nv;
        logic ill;
    } fpu_flags_t;

endpackage

// File: rtl/fpu_misc_core.sv
// Combinational sign-injection, min/max and compare for a parametrised float format.
module fpu_misc_core
    import fpu_pkg::*;
#(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23,
    localparam int unsigned W = 1 + EW + MW
) (
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic [W-1:0] y,
    output logic         nv,
    output logic         ill
);

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic           s1, s2;
    logic [EW-1:0]  e1, e2;
    logic [MW-1:0]  f1, f2;
    logic [W-2:0]   mag1, mag2;
    logic           nan1, nan2, snan1, snan2, any_nan;
    logic           both_zero, x1_lt, cmp_lt, cmp_eq;

    assign s1   = x1[W-1];
    assign s2   = x2[W-1];
    assign e1   = x1[W-2 -: EW];
    assign e2   = x2[W-2 -: EW];
    assign f1   = x1[MW-1:0];
    assign f2   = x2[MW-1:0];
    assign mag1 = x1[W-2:0];
    assign mag2 = x2[W-2:0];

    assign nan1    = (e1 == '1) && (f1 != '0);
    assign nan2    = (e2 == '1) && (f2 != '0);
    assign snan1   = nan1 && !f1[MW-1];
    assign snan2   = nan2 && !f2[MW-1];
    assign any_nan = nan1 || nan2;

    // Total order on raw bits: -0 sorts below +0 for min/max; compares treat them equal.
    assign both_zero = (mag1 == '0) && (mag2 == '0);
    assign x1_lt     = (s1 != s2) ? s1 : (s1 ? (mag2 < mag1) : (mag1 < mag2));
    assign cmp_lt    = x1_lt && !both_zero;
    assign cmp_eq    = (x1 == x2) || both_zero;

    always_comb begin
        y   = '0;
        nv  = 1'b0;
        ill = 1'b0;
        case (funct7)
            FUNCT7_SGNJ: begin
                case (funct3)
                    F3_SGNJ:  y = {s2, mag1};
                    F3_SGNJN: y = {~s2, mag1};
                    F3_SGNJX: y = {s1 ^ s2, mag1};
                    default:  ill = 1'b1;
                endcase
            end
            FUNCT7_MINMAX: begin
                if (funct3 == F3_MIN || funct3 == F3_MAX) begin
                    nv = snan1 || snan2;
                    if (nan1 && nan2) y = CANON_NAN;
                    else if (nan1)    y = x2;
                    else if (nan2)    y = x1;
                    else if (funct3 == F3_MIN) y = x1_lt ? x1 : x2;
                    else                       y = x1_lt ? x2 : x1;
                end else begin
                    ill = 1'b1;
                end
            end
            FUNCT7_CMP: begin
                case (funct3)
                    F3_FEQ: begin
                        nv   = snan1 || snan2;
                        y[0] = !any_nan && cmp_eq;
                    end
                    F3_FLT: begin
                        nv   = any_nan;
                        y[0] = !any_nan && cmp_lt;
                    end
                    F3_FLE: begin
                        nv   = any_nan;
                        y[0] = !any_nan && (cmp_lt || cmp_eq);
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_misc_pipe.sv
// Pipelined FP misc unit: combinational core into a STAGES-deep valid/ready register chain.
module fpu_misc_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned EW     = 8,
    parameter int unsigned MW     = 23,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAGW   = 5,
    localparam int unsigned W     = 1 + EW + MW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [W-1:0]    x1,
    input  logic [W-1:0]    x2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic [TAGW-1:0] out_tag,
    output logic            nv,
    output logic            ill
);

    typedef struct packed {
        logic [W-1:0]    y;
        logic [TAGW-1:0] tag;
        fpu_flags_t      flags;
    } payload_t;

    payload_t          pipe [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] advance;
    logic [W-1:0]      core_y;
    logic              core_nv, core_ill;

    fpu_misc_core #(
        .EW(EW),
        .MW(MW)
    ) u_core (
        .funct3(funct3),
        .funct7(funct7),
        .x1    (x1),
        .x2    (x2),
        .y     (core_y),
        .nv    (core_nv),
        .ill   (core_ill)
    );

    // advance[i] is high when any later stage is empty or the consumer takes the head.
    always_comb begin
        logic ready_acc;
        advance   = '0;
        ready_acc = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            advance[STAGES-1-k] = ready_acc;
            ready_acc           = ready_acc || !v[STAGES-1-k];
        end
    end

    assign in_ready = !v[0] || advance[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (in_ready) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    pipe[0].y         <= core_y;
                    pipe[0].tag       <= in_tag;
                    pipe[0].flags.nv  <= core_nv;
                    pipe[0].flags.ill <= core_ill;
                end
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (advance[i-1]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign y         = pipe[STAGES-1].y;
    assign out_tag   = pipe[STAGES-1].tag;
    assign nv        = pipe[STAGES-1].flags.nv;
    assign ill       = pipe[STAGES-1].flags.ill;

endmodule

// File: tb/tb_fpu_misc_pipe.sv
// Self-checking bench for fpu_misc_pipe: directed cases, stall/order, reset and randomized scoreboard.
module tb_fpu_misc_pipe;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
        logic        nv;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, nv, ill;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] x1, x2, y;
    logic [4:0]  in_tag, out_tag;

    logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d, nv_d, ill_d;
    logic [2:0]  funct3_d;
    logic [6:0]  funct7_d;
    logic [63:0] x1_d, x2_d, y_d;
    logic [4:0]  in_tag_d, out_tag_d;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    fpu_misc_pipe #(.EW(8), .MW(23), .STAGES(2), .TAGW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7(funct7), .x1(x1), .x2(x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag),
        .nv(nv), .ill(ill)
    );

    fpu_misc_pipe #(.EW(11), .MW(52), .STAGES(3), .TAGW(5)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .funct3(funct3_d), .funct7(funct7_d), .x1(x1_d), .x2(x2_d), .in_tag(in_tag_d),
        .out_valid(out_valid_d), .out_ready(out_ready_d), .y(y_d), .out_tag(out_tag_d),
        .nv(nv_d), .ill(ill_d)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
    endfunction

    function automatic logic is_snan(input logic [31:0] a);
        return is_nan(a) && !a[22];
    endfunction

    // Signed numeric key: sign-magnitude value mapped onto ordinary integer order.
    function automatic longint key32(input logic [31:0] a);
        longint k;
        k = longint'(a[30:0]);
        return a[31] ? -k : k;
    endfunction

    function automatic exp_t ref_op(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] tag);
        exp_t   e;
        logic   na, nb, a_first;
        longint ka, kb;
        e.y = '0; e.tag = tag; e.nv = 1'b0; e.ill = 1'b0;
        na = is_nan(a); nb = is_nan(b);
        ka = key32(a);  kb = key32(b);
        if (f7 == 7'h10 && f3 <= 3'd2) begin
            if (f3 == 3'd0)      e.y = {b[31], a[30:0]};
            else if (f3 == 3'd1) e.y = {!b[31], a[30:0]};
            else                 e.y = {a[31] ^ b[31], a[30:0]};
        end else if (f7 == 7'h14 && f3 <= 3'd1) begin
            e.nv = is_snan(a) || is_snan(b);
            if (na && nb)  e.y = 32'h7fc00000;
            else if (na)   e.y = b;
            else if (nb)   e.y = a;
            else begin
                a_first = (ka < kb) || (ka == kb && a[31]);
                if (f3 == 3'd0) e.y = a_first ? a : b;
                else            e.y = a_first ? b : a;
            end
        end else if (f7 == 7'h50 && f3 <= 3'd2) begin
            if (na || nb) begin
                e.nv = (f3 == 3'd2) ? (is_snan(a) || is_snan(b)) : 1'b1;
            end else if (f3 == 3'd2) e.y = 32'(ka == kb);
            else if (f3 == 3'd1)     e.y = 32'(ka < kb);
            else                     e.y = 32'(ka <= kb);
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return {r[31], 8'hff, 1'b1, r[21:0]};
            3: return {r[31], 8'hff, 1'b0, r[21:1], 1'b1};
            4: return {r[31], 8'hff, 23'h0};
            5: return {r[31], 8'h7f, r[22:20], 20'h0};
            default: return r;
        endcase
    endfunction

    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          output logic [31:0] ry, output logic rnv, output logic rill,
                          output logic [4:0] rtag, output int lat);
        int guard;
        out_ready = 1'b1;
        funct7 = f7; funct3 = f3; x1 = a; x2 = b; in_tag = tag; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin step(); guard++; end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin step(); lat++; end
        ry = y; rnv = nv; rill = ill; rtag = out_tag;
        step();
    endtask

    task automatic directed(input string name, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                            input logic [31:0] ey, input logic env, input logic eill);
        logic [31:0] ry;
        logic        rnv, rill;
        logic [4:0]  rtag;
        int          lat;
        run_op(f7, f3, a, b, tag, ry, rnv, rill, rtag, lat);
        check({name, "_y"},   64'(ry),   64'(ey));
        check({name, "_nv"},  64'(rnv),  64'(env));
        check({name, "_ill"}, 64'(rill), 64'(eill));
        check({name, "_tag"}, 64'(rtag), 64'(tag));
        check({name, "_lat"}, 64'(lat),  64'd2);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] sa [5];
        logic [63:0] sbv [5];
        int          idx, got, cyc, lat;
        logic        take, in_pending, held, accepted;
        logic [39:0] held_v;
        exp_t        e;

        rst = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0; funct3 = '0; funct7 = 7'h10;
        x1 = 32'h3f800000; x2 = 32'h3f800000; in_tag = 5'd3;
        in_valid_d = 1'b0; out_ready_d = 1'b0; funct3_d = '0; funct7_d = 7'h10;
        x1_d = '0; x2_d = '0; in_tag_d = '0;

        step();
        check("reset_state", {out_valid, in_ready, y, out_tag, nv, ill}, {1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0});
        rst = 1'b0; in_valid = 1'b0;
        step(); step(); step();
        check("reset_no_accept", 64'(out_valid), 64'd0);

        directed("fsgnjn",    7'h10, 3'd1, 32'h3f800000, 32'h3f800000, 5'd3,  32'hbf800000, 1'b0, 1'b0);
        directed("fmin_zero", 7'h14, 3'd0, 32'h80000000, 32'h00000000, 5'd4,  32'h80000000, 1'b0, 1'b0);
        directed("fmax_zero", 7'h14, 3'd1, 32'h80000000, 32'h00000000, 5'd11, 32'h00000000, 1'b0, 1'b0);
        directed("fmax_qnan", 7'h14, 3'd1, 32'h7fc00000, 32'h3f800000, 5'd5,  32'h3f800000, 1'b0, 1'b0);
        directed("fmax_2nan", 7'h14, 3'd1, 32'h7f800001, 32'h7fc00000, 5'd6,  32'h7fc00000, 1'b1, 1'b0);
        directed("feq_snan",  7'h50, 3'd2, 32'h7f800001, 32'h3f800000, 5'd8,  32'h0, 1'b1, 1'b0);
        directed("flt_qnan",  7'h50, 3'd1, 32'h7fc00000, 32'h3f800000, 5'd9,  32'h0, 1'b1, 1'b0);
        directed("fle",       7'h50, 3'd0, 32'hbf800000, 32'h3f800000, 5'd10, 32'h1, 1'b0, 1'b0);
        directed("feq_zeros", 7'h50, 3'd2, 32'h80000000, 32'h00000000, 5'd12, 32'h1, 1'b0, 1'b0);
        directed("illegal",   7'h00, 3'd0, 32'h12345678, 32'h9abcdef0, 5'd7,  32'h0, 1'b0, 1'b1);

        // STAGES=3 instance: back-pressure, ordering and one-per-cycle drain.
        for (int i = 0; i < 5; i++) begin
            sa[i]  = {$urandom, $urandom};
            sbv[i] = {$urandom, $urandom};
        end
        funct7_d = 7'h10; funct3_d = 3'd0; out_ready_d = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid_d = (idx < 5);
            if (idx < 5) begin x1_d = sa[idx]; x2_d = sbv[idx]; in_tag_d = 5'(idx + 1); end
            #1;
            take = in_valid_d && in_ready_d;
            step();
            if (take) idx++;
        end
        check("stall_accepts",   64'(idx),         64'd3);
        check("stall_in_ready",  64'(in_ready_d),  64'd0);
        check("stall_out_valid", 64'(out_valid_d), 64'd1);
        check("stall_hold_tag",  64'(out_tag_d),   64'd1);
        out_ready_d = 1'b1;
        got = 0; cyc = 0;
        while (got < 5 && cyc < 30) begin
            in_valid_d = (idx < 5);
            if (idx < 5) begin x1_d = sa[idx]; x2_d = sbv[idx]; in_tag_d = 5'(idx + 1); end
            #1;
            take = in_valid_d && in_ready_d;
            if (out_valid_d) begin
                check("stall_y",   y_d, {sbv[got][63], sa[got][62:0]});
                check("stall_tag", 64'(out_tag_d), 64'(got + 1));
                got++;
            end
            step();
            if (take) idx++;
            cyc++;
        end
        in_valid_d = 1'b0;
        check("stall_cycles", 64'(cyc), 64'd5);

        // Double-precision build.
        funct3_d = 3'd2; x1_d = 64'hbff0000000000000; x2_d = 64'hc000000000000000;
        in_tag_d = 5'd9; in_valid_d = 1'b1;
        #1;
        cyc = 0;
        while (!in_ready_d && cyc < 20) begin step(); cyc++; end
        step();
        in_valid_d = 1'b0;
        lat = 1;
        while (!out_valid_d && lat < 20) begin step(); lat++; end
        check("dp_fsgnjx_y",   y_d, 64'h3ff0000000000000);
        check("dp_fsgnjx_tag", 64'(out_tag_d), 64'd9);
        check("dp_latency",    64'(lat), 64'd3);
        step();

        // Randomized traffic against the reference model.
        in_pending = 1'b0; held = 1'b0; held_v = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!in_pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 9))
                    0, 1, 2: funct7 = 7'h10;
                    3, 4, 5: funct7 = 7'h14;
                    6, 7, 8: funct7 = 7'h50;
                    default: funct7 = 7'($urandom_range(0, 127));
                endcase
                funct3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                x1 = rnd_operand();
                x2 = ($urandom_range(0, 7) == 0) ? x1 : rnd_operand();
                in_tag = 5'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (held) check("rnd_hold", 64'({out_valid, y, out_tag, nv, ill}), 64'(held_v));
            held   = out_valid && !out_ready;
            held_v = {1'b1, y, out_tag, nv, ill};
            if (out_valid && out_ready) begin
                check("rnd_sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rnd_out", 64'({y, out_tag, nv, ill}), 64'({e.y, e.tag, e.nv, e.ill}));
                end
            end
            accepted = in_valid && in_ready;
            if (accepted) sb.push_back(ref_op(funct7, funct3, x1, x2, in_tag));
            in_pending = in_valid && !accepted;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && sb.size() != 0) begin
                e = sb.pop_front();
                check("drain_out", 64'({y, out_tag, nv, ill}), 64'({e.y, e.tag, e.nv, e.ill}));
            end
            step();
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_idle",  64'(out_valid), 64'd0);

        // Reset with a full pipeline must drop everything in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        funct7 = 7'h10; funct3 = 3'd0; x1 = 32'h40490fdb; x2 = 32'h80000000; in_tag = 5'd21;
        step(); step(); step();
        check("fill_full",     64'({out_valid, in_ready}), 64'b10);
        rst = 1'b1;
        step();
        check("midrst_state", {out_valid, in_ready, y, out_tag, nv, ill}, {1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 1'b0});
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("midrst_no_stale", 64'(out_valid), 64'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
